// File: rtl/debug_wr_arbiter.sv
// Shares one host-memory write channel among N_REQ debug monitors with round-robin
// grants and outstanding-ack tracking; define ARB_FIXED_PRIO_EN for fixed (lowest-index) priority.
module debug_wr_arbiter #(
    parameter int N_REQ           = 4,
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_REQ-1:0]            req_wr_in,
    input  logic [N_REQ*ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [N_REQ*DATA_WIDTH-1:0] wr_data_in,
    input  logic [N_REQ-1:0]            req_done_in,
    output logic [N_REQ-1:0]            gnt_out,
    input  logic                        wr_available,
    input  logic                        wr_valid,
    output logic                        req_wr,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic [7:0]                  outstanding,
    output logic                        ack_err,
    output logic                        all_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_COOL, S_DONE} state_t;

    state_t                  state_q;
    logic                    start_seen_q;
    logic [7:0]              outstanding_q, outstanding_d;
    logic                    ack_err_q;
    logic                    all_done_q;
    logic                    req_wr_q;
    logic [N_REQ-1:0]        gnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    logic [ADDR_WIDTH-1:0]   addr_arr [N_REQ];
    logic [DATA_WIDTH-1:0]   data_arr [N_REQ];
    logic [N_REQ-1:0]        win_onehot;
    logic [IDX_W-1:0]        win;
    logic                    any_req, can_issue, finish, ack_ok, ack_bad;

`ifdef ARB_FIXED_PRIO_EN
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] req);
        logic [IDX_W-1:0] w;
        w = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i[IDX_W-1:0]]) w = i[IDX_W-1:0];
        end
        return w;
    endfunction
`else
    logic [IDX_W-1:0] last_grant_q;

    // Scan from farthest to nearest so the requester right after last_grant overrides.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] req,
                                                     input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] w;
        int               idx;
        w = last;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (req[idx[IDX_W-1:0]]) w = idx[IDX_W-1:0];
        end
        return w;
    endfunction
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign addr_arr[g]   = wr_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g]   = wr_data_in[g*DATA_WIDTH +: DATA_WIDTH];
        assign win_onehot[g] = (win == IDX_W'(g));
    end

    always_comb begin
        any_req   = |req_wr_in;
`ifdef ARB_FIXED_PRIO_EN
        win       = pick_winner(req_wr_in);
`else
        win       = pick_winner(req_wr_in, last_grant_q);
`endif
        can_issue = (state_q == S_ARB) && wr_available && (outstanding_q < MAX_OUT) && any_req;
        finish    = (state_q == S_ARB) && start_seen_q && (&req_done_in) && !any_req
                    && (outstanding_q == 8'd0);
        ack_ok    = wr_valid && (outstanding_q != 8'd0);
        ack_bad   = wr_valid && (outstanding_q == 8'd0);
        // An issue and an ack in the same cycle cancel out.
        case ({can_issue, ack_ok})
            2'b10:   outstanding_d = outstanding_q + 8'd1;
            2'b01:   outstanding_d = outstanding_q - 8'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_seen_q  <= 1'b0;
            outstanding_q <= 8'd0;
            ack_err_q     <= 1'b0;
            all_done_q    <= 1'b0;
            req_wr_q      <= 1'b0;
            gnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_q  <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            req_wr_q      <= 1'b0;
            gnt_q         <= '0;
            outstanding_q <= outstanding_d;
            if (ack_bad) ack_err_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_ARB;
                        start_seen_q <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (can_issue) begin
                        gnt_q        <= win_onehot;
                        req_wr_q     <= 1'b1;
                        addr_q       <= addr_arr[win];
                        data_q       <= data_arr[win];
`ifndef ARB_FIXED_PRIO_EN
                        last_grant_q <= win;
`endif
                        state_q      <= S_COOL;
                    end else if (finish) begin
                        all_done_q   <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_COOL:  state_q <= S_ARB;
                S_DONE:  state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_out     = gnt_q;
    assign req_wr      = req_wr_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign outstanding = outstanding_q;
    assign ack_err     = ack_err_q;
    assign all_done    = all_done_q;

endmodule

// File: tb/tb_debug_wr_arbiter.sv
// Randomised + directed bench for debug_wr_arbiter against a rule-level reference model.
module tb_debug_wr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXO = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, wr_available, wr_valid;
    logic [N-1:0]      req_wr_in, req_done_in, gnt_out;
    logic [N*AW-1:0]   wr_addr_in;
    logic [N*DW-1:0]   wr_data_in;
    logic              req_wr, ack_err, all_done;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [7:0]        outstanding;

    debug_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .start(start), .req_wr_in(req_wr_in),
        .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .req_done_in(req_done_in),
        .gnt_out(gnt_out), .wr_available(wr_available), .wr_valid(wr_valid),
        .req_wr(req_wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .outstanding(outstanding), .ack_err(ack_err), .all_done(all_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 arbitrating, 2 cooldown, 3 finished.
    int            m_mode = 0;
    int            m_last = N - 1;
    int            m_out  = 0;
    bit            m_err  = 0;
    bit            m_done = 0;
    bit            m_reqwr = 0;
    logic [N-1:0]  m_gnt  = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    bit raise_en  = 0;
    int raise_pct = 100;
    bit ack_auto  = 0;
    int ack_pct   = 100;
    int glog[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int last);
        int w;
        w = -1;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (w < 0 && req[i]) w = i;
`else
        for (int i = last + 1; i < N; i++) if (w < 0 && req[i]) w = i;
        for (int i = 0; i <= last; i++) if (w < 0 && req[i]) w = i;
`endif
        return w;
    endfunction

    // Requesters drop after a grant and optionally raise fresh writes; memory optionally acks.
    task automatic drive_auto();
        for (int i = 0; i < N; i++) begin
            if (m_gnt[i]) begin
                req_wr_in[i] = 1'b0;
            end else if (raise_en && !req_wr_in[i] && ($urandom_range(0, 99) < raise_pct)) begin
                req_wr_in[i] = 1'b1;
                wr_addr_in[i*AW +: AW] = AW'($urandom);
                wr_data_in[i*DW +: DW] = $urandom;
            end
        end
        if (ack_auto) wr_valid = (m_out > 0) && ($urandom_range(0, 99) < ack_pct);
    endtask

    task automatic predict();
        int w;
        int delta;
        m_gnt   = '0;
        m_reqwr = 0;
        if (rst) begin
            m_mode = 0; m_last = N - 1; m_out = 0; m_err = 0; m_done = 0;
            m_addr = '0; m_data = '0;
        end else begin
            delta = 0;
            if (wr_valid) begin
                if (m_out == 0) m_err = 1;
                else delta = -1;
            end
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin
                    if (wr_available && m_out < MAXO && req_wr_in != 0) begin
                        w       = pick(req_wr_in, m_last);
                        m_gnt   = N'(1 << w);
                        m_reqwr = 1;
                        m_addr  = wr_addr_in[w*AW +: AW];
                        m_data  = wr_data_in[w*DW +: DW];
                        m_last  = w;
                        m_mode  = 2;
                        delta   = delta + 1;
                    end else if (req_done_in == '1 && req_wr_in == 0 && m_out == 0) begin
                        m_mode = 3;
                        m_done = 1;
                    end
                end
                2: m_mode = 1;
                default: ;
            endcase
            m_out = m_out + delta;
        end
    endtask

    task automatic step();
        drive_auto();
        predict();
        @(posedge clk);
        #1;
        check("gnt",      64'(gnt_out),     64'(m_gnt));
        check("req_wr",   64'(req_wr),      64'(m_reqwr));
        check("wr_addr",  64'(wr_addr),     64'(m_addr));
        check("wr_data",  64'(wr_data),     64'(m_data));
        check("outst",    64'(outstanding), 64'(m_out));
        check("ack_err",  64'(ack_err),     64'(m_err));
        check("all_done", 64'(all_done),    64'(m_done));
        for (int i = 0; i < N; i++) if (gnt_out[i]) glog.push_back(i);
    endtask

    int exp_order[8];

    initial begin
        rst = 1; start = 0; wr_available = 0; wr_valid = 0;
        req_wr_in = '0; req_done_in = '0; wr_addr_in = '0; wr_data_in = '0;
        step(); step();
        check("rst_gnt", 64'(gnt_out), 64'h0);
        check("rst_outst", 64'(outstanding), 64'h0);

        // Single requester 2 with a free channel.
        rst = 0; start = 1; wr_available = 1;
        step();
        req_wr_in = 4'b0100;
        wr_addr_in[2*AW +: AW] = 16'h2a2a;
        wr_data_in[2*DW +: DW] = 32'hd2d2_0002;
        step();
        check("t1_gnt", 64'(gnt_out), 64'h4);
        check("t1_req_wr", 64'(req_wr), 64'h1);
        check("t1_addr", 64'(wr_addr), 64'h2a2a);
        check("t1_outst", 64'(outstanding), 64'h1);
        wr_valid = 1; step(); wr_valid = 0;
        check("t1_drain", 64'(outstanding), 64'h0);

        // All requesters continuously re-raising, immediate acks.
        rst = 1; step(); rst = 0;
        raise_en = 1; raise_pct = 100; ack_auto = 1; ack_pct = 100;
        glog.delete();
        repeat (16) step();
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        check("t2_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) check("t2_order", 64'(glog[i]), 64'(exp_order[i]));

        // Reset in the middle of the burst, then a stray ack.
        rst = 1; step();
        check("t6_gnt", 64'(gnt_out), 64'h0);
        check("t6_req_wr", 64'(req_wr), 64'h0);
        check("t6_outst", 64'(outstanding), 64'h0);
        check("t6_addr", 64'(wr_addr), 64'h0);
        rst = 0; start = 0; ack_auto = 0; wr_valid = 1;
        step();
        wr_valid = 0;
        check("t6_late_ack", 64'(ack_err), 64'h1);
        start = 1; ack_auto = 1;
        step(); step();
        check("t6_first_gnt", 64'(gnt_out), 64'h1);

        // Outstanding limit with no acks, then a single ack.
        rst = 1; step(); rst = 0;
        ack_auto = 0; wr_valid = 0; glog.delete();
        repeat (12) step();
        check("t3_stall_grants", 64'(glog.size()), 64'(MAXO));
        check("t3_stall_outst", 64'(outstanding), 64'(MAXO));
        wr_valid = 1; step(); wr_valid = 0;
        repeat (6) step();
        check("t3_one_more", 64'(glog.size()), 64'(MAXO + 1));
        check("t3_outst_back", 64'(outstanding), 64'(MAXO));
        raise_en = 0; ack_auto = 1; ack_pct = 100;
        repeat (20) step();
        check("t3_drained", 64'(outstanding), 64'h0);

        // Channel unavailable for 10 cycles with requester 1 waiting.
        req_wr_in[1] = 1'b1; wr_available = 0; glog.delete();
        repeat (10) step();
        check("t4_no_issue", 64'(glog.size()), 64'h0);
        wr_available = 1;
        step();
        check("t4_gnt", 64'(gnt_out), 64'h2);

        // Completion after the last acks; extra ack afterwards.
        rst = 1; step(); rst = 0;
        ack_auto = 0; wr_valid = 0;
        req_wr_in = 4'b0111;
        repeat (8) step();
        check("t5_outst3", 64'(outstanding), 64'h3);
        req_done_in = '1;
        step();
        check("t5_wait", 64'(all_done), 64'h0);
        wr_valid = 1; step(); step(); step(); wr_valid = 0;
        check("t5_count0", 64'(outstanding), 64'h0);
        check("t5_not_yet", 64'(all_done), 64'h0);
        step();
        check("t5_done", 64'(all_done), 64'h1);
        wr_valid = 1; step(); wr_valid = 0;
        check("t5_extra_ack", 64'(ack_err), 64'h1);
        req_wr_in[0] = 1'b1; glog.delete();
        repeat (4) step();
        check("t5_no_grant", 64'(glog.size()), 64'h0);
        req_wr_in = '0; req_done_in = '0;

        // Random traffic.
        rst = 1; step(); rst = 0;
        raise_en = 1; raise_pct = 40; ack_auto = 1; ack_pct = 50;
        repeat (400) begin
            wr_available = ($urandom_range(0, 3) != 0);
            step();
        end
        raise_en = 0; ack_pct = 100; wr_available = 1;
        repeat (40) step();
        req_done_in = '1;
        repeat (4) step();
        check("rand_done", 64'(all_done), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
